// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one async-FIFO write port.
// Write-clock domain only; optional burst lock via ARB_BURST_LOCK_EN.
//
// Ports:
//   wclk, wrst_n      write clock, sync active-low reset
//   req, wdata_in     per-requester valid and data slice
//   wfull             registered FIFO full flag
//   gnt, winc, wdata  accept strobe, FIFO write enable and data
//   gnt_id            last granted requester (registered)
//   stall_cnt         saturating count of cycles with |req && wfull
module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int CNTW      = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DSIZE-1:0]    wdata_in,
  input  logic                     wfull,
  output logic [NREQ-1:0]          gnt,
  output logic                     winc,
  output logic [DSIZE-1:0]         wdata,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic [CNTW-1:0]          stall_cnt
);

  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || MAX_BURST < 1) begin : g_cfg_err
    $error("fifo_wr_arb: NREQ must be >=2 and MAX_BURST >=1");
  end

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   gnt_id_q, gnt_id_d;
  logic [CNTW-1:0] stall_q, stall_d;
  logic [PW-1:0]   sel, sel_hi, sel_lo, win;
  logic            hit_hi, any_req, acc;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
    return (x == PW'(NREQ-1)) ? '0 : x + 1'b1;
  endfunction

  // Cyclic scan from rr_ptr: lowest request at or above the pointer
  // wins, else the lowest request overall.
  always_comb begin
    hit_hi = 1'b0;
    sel_hi = '0;
    sel_lo = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req[i]) begin
        sel_lo = PW'(i);
        if (PW'(i) >= rr_ptr_q) begin
          sel_hi = PW'(i);
          hit_hi = 1'b1;
        end
      end
    end
    sel = hit_hi ? sel_hi : sel_lo;
  end

  assign any_req = |req;

  always_comb begin
    stall_d = stall_q;
    if (any_req && wfull && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
  end

`ifdef ARB_BURST_LOCK_EN
  localparam int BW = $clog2(MAX_BURST+1);
  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [BW-1:0] beats_q, beats_d;
  logic          own_req;

  always_comb begin
    own_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == owner_q) own_req = req[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    beats_d  = beats_q;
    rr_ptr_d = rr_ptr_q;
    gnt_id_d = gnt_id_q;
    acc      = 1'b0;
    win      = sel;
    unique case (state_q)
      ARB: begin
        if (wrst_n && !wfull && any_req) begin
          acc      = 1'b1;
          gnt_id_d = sel;
          if (MAX_BURST > 1) begin
            state_d = LOCK;
            owner_d = sel;
            beats_d = BW'(1);
          end else begin
            rr_ptr_d = wrap_inc(sel);
          end
        end
      end
      LOCK: begin
        win = owner_q;
        // Full just stalls the lock; a dropped owner request
        // releases it at the cost of one bubble.
        if (!wfull) begin
          if (own_req) begin
            acc      = wrst_n;
            gnt_id_d = owner_q;
            if (beats_q == BW'(MAX_BURST-1)) begin
              state_d  = ARB;
              rr_ptr_d = wrap_inc(owner_q);
            end else begin
              beats_d = beats_q + 1'b1;
            end
          end else begin
            state_d  = ARB;
            rr_ptr_d = wrap_inc(owner_q);
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q <= ARB;
      owner_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beats_q <= beats_d;
    end
  end
`else
  always_comb begin
    acc      = wrst_n && !wfull && any_req;
    win      = sel;
    rr_ptr_d = acc ? wrap_inc(sel) : rr_ptr_q;
    gnt_id_d = acc ? sel : gnt_id_q;
  end
`endif

  always_comb begin
    gnt   = '0;
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (acc && win == PW'(i)) begin
        gnt[i] = 1'b1;
        wdata  = wdata_in[i*DSIZE +: DSIZE];
      end
    end
  end

  assign winc      = acc;
  assign gnt_id    = gnt_id_q;
  assign stall_cnt = stall_q;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      rr_ptr_q <= '0;
      gnt_id_q <= '0;
      stall_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
      stall_q  <= stall_d;
    end
  end

endmodule
